ber_disp: RTL and testbench
===========================

BER_DISP -- requirements
Module: ber_disp

Interface
REQ-001 SHALL have parameter EW, default 64: error-count width.
REQ-002 SHALL have parameter RW, default 58: received-count width.
REQ-003 SHALL have parameter RECV_SHIFT, default 6: log2 of bits per RECV_CNT unit; bit count D = RECV_CNT << RECV_SHIFT.
REQ-004 SHALL have parameter MANT_DIGITS (M), default 3, legal range 1..4: displayed mantissa digits.
REQ-005 SHALL have parameter EXP_MAX, default 18, legal range 1..99: largest displayable negative exponent.
REQ-006 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts all SEG and DP bits.
REQ-007 SHALL have port CLK, input, 1 bit: the only clock, rising edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port START, input, 1 bit: capture inputs and begin a conversion.
REQ-010 SHALL have port ERR_CNT, input, EW bits: error count.
REQ-011 SHALL have port RECV_CNT, input, RW bits: received count in 2^RECV_SHIFT-bit units.
REQ-012 SHALL have port SEG, output, 7*(M+2) bits: digit k occupies SEG[7k+6:7k], bit order {g,f,e,d,c,b,a}; k=0 exponent ones, k=1 exponent tens, k=2..M+1 mantissa least to most significant.
REQ-013 SHALL have port DP, output, M+2 bits: decimal point per digit.
REQ-014 SHALL have port STATUS, output, 2 bits: 0 OK, 1 ZERO_ERR, 2 NO_DATA, 3 UNDERFLOW.
REQ-015 SHALL have port BUSY, output, 1 bit: conversion in progress.
REQ-016 SHALL have port DONE, output, 1 bit: one-cycle pulse when SEG, DP and STATUS update.

Function
REQ-017 SHALL display BER = ERR/D as mantissa m x 10^-e; mantissa digits show floor(m * 10^(M-1)); the exponent shows e in two decimal digits.
REQ-018 SHALL use active-high segment codes 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00 (hex).
REQ-019 SHALL set DP only on the mantissa MSD, and only when M>1 and STATUS is OK or ZERO_ERR.
REQ-020 SHALL implement FSM IDLE -> LOAD -> NORM -> SCALE -> DIV -> CONV -> IDLE; BUSY=1 in every state except IDLE.
REQ-021 On START=1 in any state, SHALL capture ERR_CNT/RECV_CNT and enter LOAD, aborting any conversion in progress, with outputs held.
REQ-022 In LOAD, if D==0, SHALL finish with STATUS=NO_DATA and all digits dash; NO_DATA takes priority over ZERO_ERR.
REQ-023 In LOAD, if ERR==0, SHALL finish with STATUS=ZERO_ERR, all mantissa digits 0 and exponent 00.
REQ-024 Otherwise LOAD SHALL set n=ERR and e=0.
REQ-025 In each NORM cycle: if n>=D, SHALL go to SCALE; else if e==EXP_MAX, SHALL finish with STATUS=UNDERFLOW, mantissa dashes and exponent EXP_MAX; else SHALL set n=n*10 and e=e+1.
REQ-026 SCALE SHALL take M-1 cycles, each computing n=n*10.
REQ-027 DIV SHALL be a restoring divider of width NW = RW+RECV_SHIFT+14, one quotient bit per cycle (NW cycles), computing q=floor(n/D).
REQ-028 The datapath SHALL be NW bits wide and SHALL never overflow.
REQ-029 If q >= 10^M (input BER>1), SHALL saturate q to 10^M-1 with STATUS=OK.
REQ-030 CONV SHALL be a 14-cycle shift-add-3 binary-to-BCD conversion of q.
REQ-031 SHALL fix done-latency L (cycles from the START edge to the DONE pulse): L=2 for NO_DATA/ZERO_ERR; L=3+EXP_MAX for UNDERFLOW; L=3+e+(M-1)+NW+14 for OK.
REQ-032 SHALL assert DONE with updated outputs in the same cycle BUSY falls; outputs SHALL otherwise hold their last result.
REQ-033 START asserted in the same cycle as DONE SHALL take effect: DONE still pulses and a new conversion begins.

Reset
REQ-034 With RST=1 at a CLK edge, SHALL enter IDLE and set SEG to all blank, DP=0, STATUS=0, BUSY=0, DONE=0, both honoring SEG_ACTIVE_LOW.
REQ-035 RST SHALL override START, and RST mid-conversion SHALL discard the conversion.

Verification (default parameters, NW=78)
REQ-036 ERR=3, RECV=1000 -> SEG "4.68" "05", STATUS=0, DONE at L=102.
REQ-037 ERR=1, RECV=2^40 -> "1.42" "14", STATUS=0, L=111.
REQ-038 ERR=0, RECV=5 -> "0.00" "00", STATUS=1, L=2; ERR=7, RECV=0 -> all dashes, STATUS=2, L=2.
REQ-039 ERR=1, RECV=2^57 -> mantissa dashes, "18", STATUS=3, L=21; ERR=200, RECV=1 -> "9.99" "00", STATUS=0.
REQ-040 START re-asserted 40 cycles into the ERR=3 case with ERR=0 -> previous outputs held until DONE at 2 cycles after the second START, then ZERO_ERR display.
REQ-041 RST pulse mid-conversion -> next cycle BUSY=0, SEG blank, no DONE; with SEG_ACTIVE_LOW=1, SEG reset value is all ones.

Source files
------------

// File: rtl/ber_disp.sv
// Bit-error-rate to 7-segment display converter: ERR/D shown as m.mm x 10^-ee.
// Sequential normalise / scale / restoring divide / double-dabble datapath.
module ber_disp #(
  parameter int unsigned EW             = 64,
  parameter int unsigned RW             = 58,
  parameter int unsigned RECV_SHIFT     = 6,
  parameter int unsigned MANT_DIGITS    = 3,
  parameter int unsigned EXP_MAX        = 18,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [EW-1:0]                  ERR_CNT,
  input  logic [RW-1:0]                  RECV_CNT,
  output logic [7*(MANT_DIGITS+2)-1:0]   SEG,
  output logic [MANT_DIGITS+1:0]         DP,
  output logic [1:0]                     STATUS,
  output logic                           BUSY,
  output logic                           DONE
);

  localparam int unsigned M  = MANT_DIGITS;
  localparam int unsigned ND = M + 2;
  localparam int unsigned NW = RW + RECV_SHIFT + 14;
  localparam int unsigned CW = $clog2(NW + 1);
  localparam logic [NW-1:0] QLIM = NW'(10 ** M);
  localparam logic [13:0]   QSAT = 14'(10 ** M - 1);
  localparam logic [3:0]    DASH = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_NORM, S_SCALE, S_DIV, S_CONV
  } state_e;

  typedef enum logic [1:0] {
    ST_OK, ST_ZERO, ST_NODATA, ST_UNDER
  } status_e;

  state_e            state_q, state_d;
  status_e           pend_q, pend_d;
  status_e           status_q, status_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     d_q, d_d;
  logic [NW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [6:0]        e_q, e_d;
  logic [3:0]        elo_q, elo_d;
  logic [3:0]        ehi_q, ehi_d;
  logic              over_q, over_d;
  logic [29:0]       sh_q, sh_d;
  logic [7*ND-1:0]   seg_q, seg_d;
  logic [ND-1:0]     dp_q, dp_d;
  logic              done_q, done_d;

  logic [NW:0]       rem_sh;
  logic              qbit;
  logic              sat;
  logic [29:0]       dabble;
  logic [3:0]        code;
  logic [7*ND-1:0]   disp_seg;
  logic [ND-1:0]     disp_dp;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      4'd10:   seg7 = 7'h40;
      default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [NW-1:0] mul10(input logic [NW-1:0] v);
    mul10 = (v << 3) + (v << 1);
  endfunction

  // Display image for the pending result; k=0,1 exponent, k>=2 mantissa LSD..MSD.
  always_comb begin
    disp_seg = '0;
    disp_dp  = '0;
    code     = '0;
    for (int unsigned k = 0; k < ND; k++) begin
      if (pend_q == ST_NODATA)  code = DASH;
      else if (k == 0)          code = elo_q;
      else if (k == 1)          code = ehi_q;
      else if (pend_q == ST_UNDER) code = DASH;
      else if (pend_q == ST_ZERO)  code = 4'd0;
      else                      code = sh_q[14 + 4*(k-2) +: 4];
      disp_seg[7*k +: 7] = seg7(code);
    end
    if (M > 1 && (pend_q == ST_OK || pend_q == ST_ZERO))
      disp_dp[ND-1] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    status_d = status_q;
    n_d      = n_q;
    d_d      = d_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    elo_d    = elo_q;
    ehi_d    = ehi_q;
    over_d   = over_q;
    sh_d     = sh_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    done_d   = 1'b0;
    rem_sh   = {rem_q, n_q[NW-1]};
    qbit     = (rem_sh >= {1'b0, d_q});
    sat      = 1'b0;
    dabble   = sh_q;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        e_d    = '0;
        elo_d  = '0;
        ehi_d  = '0;
        rem_d  = '0;
        cnt_d  = '0;
        over_d = (n_q > d_q);
        if (d_q == '0) begin
          pend_d  = ST_NODATA;
          state_d = S_CONV;
        end else if (n_q == '0) begin
          pend_d  = ST_ZERO;
          state_d = S_CONV;
        end else begin
          pend_d  = ST_OK;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (n_q >= d_q) begin
          state_d = (M > 1) ? S_SCALE : S_DIV;
          cnt_d   = '0;
        end else if (e_q == 7'(EXP_MAX)) begin
          pend_d  = ST_UNDER;
          state_d = S_CONV;
        end else begin
          n_d = mul10(n_q);
          e_d = e_q + 7'd1;
          if (elo_q == 4'd9) begin
            elo_d = '0;
            ehi_d = ehi_q + 4'd1;
          end else begin
            elo_d = elo_q + 4'd1;
          end
        end
      end
      S_SCALE: begin
        n_d = mul10(n_q);
        if (cnt_q == CW'(M - 2)) begin
          state_d = S_DIV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        rem_d = qbit ? NW'(rem_sh - {1'b0, d_q}) : rem_sh[NW-1:0];
        n_d   = {n_q[NW-2:0], qbit};
        if (cnt_q == CW'(NW - 1)) begin
          // Any BER above one saturates, even when the quotient would still fit.
          sat     = over_q || (n_d >= QLIM);
          sh_d    = {16'h0000, sat ? QSAT : n_d[13:0]};
          state_d = S_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONV: begin
        if (pend_q != ST_OK || cnt_q == CW'(14)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          status_d = pend_q;
          seg_d    = disp_seg;
          dp_d     = disp_dp;
        end else begin
          for (int unsigned j = 0; j < 4; j++)
            if (dabble[14 + 4*j +: 4] >= 4'd5)
              dabble[14 + 4*j +: 4] = dabble[14 + 4*j +: 4] + 4'd3;
          sh_d  = dabble << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A finishing conversion still commits its result when START coincides.
    if (START) begin
      state_d = S_LOAD;
      n_d     = NW'(ERR_CNT);
      d_d     = NW'(RECV_CNT) << RECV_SHIFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pend_q   <= ST_OK;
      status_q <= ST_OK;
      n_q      <= '0;
      d_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      e_q      <= '0;
      elo_q    <= '0;
      ehi_q    <= '0;
      over_q   <= 1'b0;
      sh_q     <= '0;
      seg_q    <= '0;
      dp_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      status_q <= status_d;
      n_q      <= n_d;
      d_q      <= d_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      elo_q    <= elo_d;
      ehi_q    <= ehi_d;
      over_q   <= over_d;
      sh_q     <= sh_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      done_q   <= done_d;
    end
  end

  assign SEG    = seg_q ^ {(7*ND){SEG_ACTIVE_LOW}};
  assign DP     = dp_q ^ {ND{SEG_ACTIVE_LOW}};
  assign STATUS = status_q;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = done_q;

endmodule

// File: tb/tb_ber_disp.sv
// Scoreboard bench for ber_disp: arithmetic BER model feeds a queue, a monitor
// checks DONE timing, display, status and busy on every falling edge.
module tb_ber_disp;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] err_cnt;
  logic [57:0] recv_cnt;
  logic [34:0] seg, seg_al;
  logic [4:0]  dp, dp_al;
  logic [1:0]  status, status_al;
  logic        busy, busy_al, done, done_al;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [34:0] seg;
    logic [4:0]  dp;
    logic [1:0]  st;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [34:0] held_seg, held_seg_al;
  logic [4:0]  held_dp, held_dp_al;
  logic [1:0]  held_st;
  logic [6:0]  segtab [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40};

  ber_disp dut (
    .CLK(clk), .RST(rst), .START(start), .ERR_CNT(err_cnt), .RECV_CNT(recv_cnt),
    .SEG(seg), .DP(dp), .STATUS(status), .BUSY(busy), .DONE(done)
  );

  ber_disp #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
    .CLK(clk), .RST(rst), .START(start), .ERR_CNT(err_cnt), .RECV_CNT(recv_cnt),
    .SEG(seg_al), .DP(dp_al), .STATUS(status_al), .BUSY(busy_al), .DONE(done_al)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // BER = err / (recv*64) written as q/100 x 10^-e with the smallest e reaching >= 1.
  function automatic exp_t model(input logic [63:0] err, input logic [57:0] recv, input int sc);
    exp_t         r;
    logic [127:0] d, p, q, ew;
    int           e, lat;
    int           dig[5];
    d  = {70'd0, recv} << 6;
    ew = {64'd0, err};
    r.st = 2'd0;
    if (d == 0) begin
      r.st = 2'd2;
      foreach (dig[k]) dig[k] = 10;
      lat = 2;
    end else if (err == 0) begin
      r.st = 2'd1;
      foreach (dig[k]) dig[k] = 0;
      lat = 2;
    end else begin
      e = 0;
      p = 1;
      while (ew * p < d && e <= 18) begin
        p = p * 10;
        e++;
      end
      if (e > 18) begin
        r.st   = 2'd3;
        dig[0] = 8;
        dig[1] = 1;
        dig[2] = 10;
        dig[3] = 10;
        dig[4] = 10;
        lat    = 3 + 18;
      end else begin
        q = (ew * p * 100) / d;
        if (ew > d || q >= 1000) q = 999;
        dig[0] = e % 10;
        dig[1] = e / 10;
        dig[2] = int'(q % 10);
        dig[3] = int'((q / 10) % 10);
        dig[4] = int'(q / 100);
        lat    = 3 + e + 2 + 78 + 14;
      end
    end
    for (int k = 0; k < 5; k++) r.seg[7*k +: 7] = segtab[dig[k]];
    r.dp       = (r.st <= 2'd1) ? 5'b10000 : 5'b00000;
    r.done_cyc = sc + lat;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_done;
      exp_t ent;
      exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
      chk("done", done, exp_done);
      chk("done_al", done_al, exp_done);
      if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
        ent         = sb.pop_front();
        held_seg    = ent.seg;
        held_dp     = ent.dp;
        held_st     = ent.st;
        held_seg_al = ~ent.seg;
        held_dp_al  = ~ent.dp;
      end
      chk("seg", seg, held_seg);
      chk("dp", dp, held_dp);
      chk("status", status, held_st);
      chk("busy", busy, sb.size() != 0);
      chk("seg_al", seg_al, held_seg_al);
      chk("dp_al", dp_al, held_dp_al);
      chk("status_al", status_al, held_st);
      chk("busy_al", busy_al, sb.size() != 0);
    end
  end

  task automatic set_blank();
    held_seg    = '0;
    held_dp     = '0;
    held_st     = '0;
    held_seg_al = '1;
    held_dp_al  = '1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that sampled START.
  task automatic issue(input logic [63:0] err, input logic [57:0] recv);
    err_cnt  = err;
    recv_cnt = recv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (sb.size() > 0) void'(sb.pop_back());
    sb.push_back(model(err, recv, cyc));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
  endtask

  task automatic run(input logic [63:0] err, input logic [57:0] recv);
    issue(err, recv);
    wait_done();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64, e64;
    logic [57:0] one58;
    rst      = 1'b1;
    start    = 1'b0;
    err_cnt  = '0;
    recv_cnt = '0;
    set_blank();
    idle(2);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    one58 = 58'd1;
    run(64'd3, 58'd1000);
    run(64'd1, one58 << 40);
    run(64'd0, 58'd5);
    run(64'd7, 58'd0);
    run(64'd0, 58'd0);
    run(64'd1, one58 << 57);
    run(64'd200, 58'd1);
    run(64'd64, 58'd1);
    run(64'hFFFF_FFFF_FFFF_FFFF, 58'd1);
    run(64'd1, 58'd15625000000000000);
    run(64'd1, 58'd15625000000000001);
    idle(3);

    // Restart 40 cycles into a conversion; previous display must hold.
    issue(64'd3, 58'd1000);
    idle(39);
    issue(64'd0, 58'd5);
    wait_done();

    // Reset mid-conversion, also while START is high.
    issue(64'd3, 58'd1000);
    idle(30);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    while (sb.size() > 0) void'(sb.pop_back());
    set_blank();
    idle(120);

    for (int i = 0; i < 40; i++) begin
      r64 = {$urandom(), $urandom()};
      e64 = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) r64 = '0;
      else r64 = r64 >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) e64 = '0;
      else e64 = e64 >> $urandom_range(0, 63);
      run(e64, r64[57:0]);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
